// File: rtl/sync_tgl_hs_resp_if.sv
// Bundle of the toggle-handshake request/acknowledge signals and the local
// valid/ready payload port seen by the destination-side responder.
//
// Handshake rules on the consumer side (out_pvld/out_prdy):
//   - A transfer happens on a rising clk edge where out_pvld && out_prdy.
//   - Once out_pvld is high it stays high, and out_pd stays constant,
//     until that transfer happens.
//   - out_prdy may be high before out_pvld rises; out_pvld never waits on it.
interface sync_tgl_hs_resp_if #(
    parameter int DW   = 32,
    parameter int CNTW = 16
);
    logic            req_tgl_sync;
    logic [DW-1:0]   src_pd;
    logic            ack_tgl;
    logic            out_pvld;
    logic            out_prdy;
    logic [DW-1:0]   out_pd;
    logic            busy;
    logic            ovr_err;
    logic [CNTW-1:0] xfer_cnt;
    logic [1:0]      state_dbg;

    // Responder view
    modport slave (
        input  req_tgl_sync, src_pd, out_prdy,
        output ack_tgl, out_pvld, out_pd, busy, ovr_err, xfer_cnt, state_dbg
    );

    // Source/consumer view
    modport master (
        output req_tgl_sync, src_pd, out_prdy,
        input  ack_tgl, out_pvld, out_pd, busy, ovr_err, xfer_cnt, state_dbg
    );
endinterface

// File: rtl/sync_tgl_hs_resp.sv
// Destination-side responder of a toggle req/ack crossing: detects a
// request toggle edge, lets the quasi-static payload settle, captures it,
// offers it to a local valid/ready consumer and returns an ack toggle.
// Every output is a flop or a decode of the registered state.
module sync_tgl_hs_resp #(
    parameter int DW         = 32,
    parameter int SETTLE_CYC = 2,
    parameter int CNTW       = 16
) (
    input  logic           clk,
    input  logic           rst,
    sync_tgl_hs_resp_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_VALID  = 2'd2
    } state_t;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC - 1);

    state_t          state_q, state_d;
    logic            req_q, req_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [DW-1:0]   pd_q, pd_d;
    logic            ack_q, ack_d;
    logic [CNTW-1:0] xfer_q, xfer_d;
    logic            ovr_q, ovr_d;
    logic            req_edge;

    // Any change of the synchronized toggle against last cycle is a request
    assign req_edge = bus.req_tgl_sync ^ req_q;

    // Next-state and datapath: edge -> settle countdown -> capture -> offer
    always_comb begin
        state_d = state_q;
        req_d   = bus.req_tgl_sync;
        cnt_d   = cnt_q;
        pd_d    = pd_q;
        ack_d   = ack_q;
        xfer_d  = xfer_q;
        ovr_d   = ovr_q;

        // An edge arriving while a transfer is in flight is not queued;
        // it only flags the protocol violation.
        if (req_edge && (state_q != ST_IDLE)) begin
            ovr_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (req_edge) begin
                    state_d = ST_SETTLE;
                    cnt_d   = SETTLE_INIT;
                end
            end
            ST_SETTLE: begin
                if (cnt_q == 4'd0) begin
                    pd_d    = bus.src_pd;
                    state_d = ST_VALID;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_VALID: begin
                if (bus.out_prdy) begin
                    state_d = ST_IDLE;
                    ack_d   = ~ack_q;
                    xfer_d  = xfer_q + CNTW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously by rst
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            req_q   <= 1'b0;
            cnt_q   <= 4'd0;
            pd_q    <= '0;
            ack_q   <= 1'b0;
            xfer_q  <= '0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            cnt_q   <= cnt_d;
            pd_q    <= pd_d;
            ack_q   <= ack_d;
            xfer_q  <= xfer_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.ack_tgl   = ack_q;
    assign bus.out_pvld  = (state_q == ST_VALID);
    assign bus.out_pd    = pd_q;
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.ovr_err   = ovr_q;
    assign bus.xfer_cnt  = xfer_q;
    assign bus.state_dbg = state_q;

endmodule

// File: tb/tb_sync_tgl_hs_resp.sv
// Bench for sync_tgl_hs_resp: directed scenarios with literal expectations
// followed by randomized traffic, all outputs compared every cycle against a
// timestamp-based model of the transfer rules.
module tb_sync_tgl_hs_resp;

    localparam int DW     = 32;
    localparam int SETTLE = 2;
    localparam int CNTW   = 2;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    sync_tgl_hs_resp_if #(.DW(DW), .CNTW(CNTW)) bus ();

    sync_tgl_hs_resp #(.DW(DW), .SETTLE_CYC(SETTLE), .CNTW(CNTW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_vec = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];
    logic src_tgl;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model + compare ----------------
    // A transfer is described by the cycle its edge was accepted (m_t0):
    // payload sampled at m_t0+SETTLE, valid from m_t0+SETTLE+1 until taken.
    int          cyc = 0;
    int          m_t0;
    int          m_cnt;
    bit          m_active, m_pvld, m_ack, m_ovr, m_req_prev, m_edge;
    logic [DW-1:0] m_pd;

    always @(negedge clk) begin
        if (rst) begin
            check("rst_ack", 32'(bus.ack_tgl), 32'(0));
            check("rst_pvld", 32'(bus.out_pvld), 32'(0));
            check("rst_pd", bus.out_pd, 32'(0));
            check("rst_busy", 32'(bus.busy), 32'(0));
            check("rst_ovr", 32'(bus.ovr_err), 32'(0));
            check("rst_cnt", 32'(bus.xfer_cnt), 32'(0));
            m_active = 0; m_pvld = 0; m_ack = 0; m_ovr = 0; m_req_prev = 0;
            m_cnt = 0; m_pd = '0; m_t0 = 0;
            exp_q.delete();
        end else begin
            check("out_pvld", 32'(bus.out_pvld), 32'(m_pvld));
            check("out_pd", bus.out_pd, m_pd);
            check("ack_tgl", 32'(bus.ack_tgl), 32'(m_ack));
            check("busy", 32'(bus.busy), 32'(m_active));
            check("ovr_err", 32'(bus.ovr_err), 32'(m_ovr));
            check("xfer_cnt", 32'(bus.xfer_cnt), 32'(m_cnt % (1 << CNTW)));

            m_edge     = (bus.req_tgl_sync != m_req_prev);
            m_req_prev = bus.req_tgl_sync;
            if (m_active) begin
                if (m_edge) m_ovr = 1;
                if (cyc == m_t0 + SETTLE) m_pd = bus.src_pd;
                if (m_pvld && bus.out_prdy) begin
                    if (exp_q.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL sb_unexpected_xfer: got %0h expected none", bus.out_pd);
                    end else begin
                        check("sb_payload", bus.out_pd, exp_q.pop_front());
                    end
                    m_active = 0;
                    m_ack    = ~m_ack;
                    m_cnt++;
                end
            end else if (m_edge) begin
                m_active = 1;
                m_t0     = cyc;
            end
            m_pvld = m_active && (cyc >= m_t0 + SETTLE);
        end
        cyc++;
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic toggle_req();
        src_tgl = ~src_tgl;
        bus.req_tgl_sync = src_tgl;
    endtask

    task automatic send(input logic [DW-1:0] pd);
        bus.src_pd = pd;
        exp_q.push_back(pd);
        toggle_req();
    endtask

    task automatic wait_ack(input logic prev, input bit rand_rdy);
        bit ok = 0;
        for (int i = 0; i < 100 && !ok; i++) begin
            if (bus.ack_tgl != prev) ok = 1;
            else begin
                if (rand_rdy) bus.out_prdy = 1'($urandom_range(0, 1));
                tick();
            end
        end
        n_vec++;
        if (!ok) begin
            n_err++;
            $display("FAIL ack_timeout: got ack=%0b expected %0b", bus.ack_tgl, ~prev);
        end
    endtask

    task automatic sample();
        @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic prev;
        rst = 1'b1;
        src_tgl = 1'b0;
        bus.req_tgl_sync = 1'b0;
        bus.src_pd = '0;
        bus.out_prdy = 1'b0;

        // Reset with random inputs
        repeat (5) begin
            tick();
            bus.req_tgl_sync = 1'($urandom_range(0, 1));
            bus.src_pd = $urandom;
            bus.out_prdy = 1'($urandom_range(0, 1));
        end
        tick();
        src_tgl = 1'b0;
        bus.req_tgl_sync = 1'b0;
        bus.src_pd = '0;
        bus.out_prdy = 1'b1;
        tick();
        rst = 1'b0;
        repeat (20) tick();
        check("idle_busy", 32'(bus.busy), 32'(0));
        check("idle_state", 32'(bus.state_dbg), 32'(0));

        // Single transfer, consumer ready in advance
        send(32'hDEADBEEF);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("single_not_yet_valid", 32'(bus.out_pvld), 32'(0));
        sample();
        check("single_valid", 32'(bus.out_pvld), 32'(1));
        check("single_pd", bus.out_pd, 32'hDEADBEEF);
        sample();
        check("single_ack", 32'(bus.ack_tgl), 32'(1));
        check("single_cnt", 32'(bus.xfer_cnt), 32'(1));
        check("single_pvld_drop", 32'(bus.out_pvld), 32'(0));
        tick();

        // Consumer backpressure for 7 cycles
        bus.out_prdy = 1'b0;
        send(32'hCAFE0001);
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("bp_valid", 32'(bus.out_pvld), 32'(1));
        repeat (7) begin
            sample();
            check("bp_hold_pvld", 32'(bus.out_pvld), 32'(1));
            check("bp_hold_pd", bus.out_pd, 32'hCAFE0001);
            check("bp_hold_ack", 32'(bus.ack_tgl), 32'(1));
        end
        @(posedge clk);
        #1;
        bus.out_prdy = 1'b1;
        sample();
        check("bp_ack", 32'(bus.ack_tgl), 32'(0));
        check("bp_cnt", 32'(bus.xfer_cnt), 32'(2));
        tick();

        // Overrun: second toggle during SETTLE
        send(32'h00005A5A);
        tick();
        tick();
        toggle_req();
        repeat (6) tick();
        check("ovr_set", 32'(bus.ovr_err), 32'(1));
        check("ovr_one_ack", 32'(bus.ack_tgl), 32'(1));
        check("ovr_one_cnt", 32'(bus.xfer_cnt), 32'(3));
        check("ovr_idle", 32'(bus.busy), 32'(0));
        repeat (10) tick();
        check("ovr_sticky", 32'(bus.ovr_err), 32'(1));

        // Reset clears the sticky error
        rst = 1'b1;
        src_tgl = 1'b0;
        bus.req_tgl_sync = 1'b0;
        tick();
        check("ovr_cleared", 32'(bus.ovr_err), 32'(0));
        rst = 1'b0;
        tick();

        // Back-to-back, each request issued as soon as the ack is seen
        bus.out_prdy = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            prev = bus.ack_tgl;
            send(DW'(k));
            wait_ack(prev, 1'b0);
        end
        check("b2b_ack", 32'(bus.ack_tgl), 32'(0));
        check("b2b_cnt_wrap", 32'(bus.xfer_cnt), 32'(0));
        check("b2b_ovr", 32'(bus.ovr_err), 32'(0));

        // Reset while VALID
        prev = bus.ack_tgl;
        send(32'h0BADF00D);
        wait_ack(prev, 1'b0);
        bus.out_prdy = 1'b0;
        send(32'h12345678);
        repeat (4) tick();
        check("pre_rst_valid", 32'(bus.out_pvld), 32'(1));
        check("pre_rst_ack", 32'(bus.ack_tgl), 32'(1));
        rst = 1'b1;
        src_tgl = 1'b0;
        bus.req_tgl_sync = 1'b0;
        #1;
        check("async_rst_pvld", 32'(bus.out_pvld), 32'(0));
        check("async_rst_ack", 32'(bus.ack_tgl), 32'(0));
        tick();
        rst = 1'b0;
        bus.out_prdy = 1'b1;
        repeat (20) tick();
        check("post_rst_pvld", 32'(bus.out_pvld), 32'(0));
        check("post_rst_cnt", 32'(bus.xfer_cnt), 32'(0));

        // Randomized traffic with random consumer stalls and rare overruns
        for (int n = 0; n < 150; n++) begin
            repeat ($urandom_range(0, 3)) begin
                bus.out_prdy = 1'($urandom_range(0, 1));
                tick();
            end
            prev = bus.ack_tgl;
            send($urandom);
            if ($urandom_range(0, 7) == 0) begin
                repeat ($urandom_range(1, 2)) tick();
                toggle_req();
            end
            wait_ack(prev, 1'b1);
        end
        bus.out_prdy = 1'b1;
        repeat (5) tick();
        check("final_idle", 32'(bus.busy), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
